// File: rtl/control_seq.sv
// Multicycle control sequencer for the RV32 core: decodes IR fields per state and
// drives every datapath strobe/select, with memory timeout, mul/div handshake and debug halt.
module control_seq #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit MULDIV_EN   = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [2:0] f3,
  input  logic       f7_md,
  input  logic       mem_complete,
  input  logic       exception,
  input  logic       interrupt_pending,
  input  logic       halt_req,
  input  logic       resume_req,
  input  logic       md_done,
  output logic       write_ir,
  output logic       write_pc,
  output logic       write_pc_ne,
  output logic       write_pc_ex,
  output logic       write_rd,
  output logic       write_csr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       md_start,
  output logic       addr_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] alu_insel1,
  output logic [1:0] alu_insel2,
  output logic       bus_error,
  output logic       illegal,
  output logic       halted
);

  localparam logic [3:0] S_FETCH      = 4'd0;
  localparam logic [3:0] S_DISPATCH   = 4'd1;
  localparam logic [3:0] S_LOAD_WAIT  = 4'd2;
  localparam logic [3:0] S_LOAD_WB    = 4'd3;
  localparam logic [3:0] S_STORE_WAIT = 4'd4;
  localparam logic [3:0] S_STORE_DONE = 4'd5;
  localparam logic [3:0] S_MD_START   = 4'd6;
  localparam logic [3:0] S_MD_WAIT    = 4'd7;
  localparam logic [3:0] S_WFI        = 4'd8;
  localparam logic [3:0] S_HALTED     = 4'd9;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  localparam bit               TO_EN    = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  logic [3:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             retire, trap;

  always_comb begin
    write_ir    = 1'b0;
    write_pc    = 1'b0;
    write_pc_ne = 1'b0;
    write_pc_ex = 1'b0;
    write_rd    = 1'b0;
    write_csr   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    md_start    = 1'b0;
    addr_sel    = 1'b0;
    rd_sel      = 2'd0;
    alu_insel1  = 2'd0;
    alu_insel2  = 2'd0;
    bus_error   = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    retire      = 1'b0;
    trap        = 1'b0;
    state_nxt   = state;

    case (state)
      S_FETCH: begin
        // A halt is only taken before the fetch has started waiting on memory
        if (cnt == '0 && halt_req) begin
          state_nxt = S_HALTED;
        end else begin
          mem_read = 1'b1;
          if (mem_complete) state_nxt = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        case (opcode)
          OP_LUI:    begin alu_insel1 = 2'd2; alu_insel2 = 2'd1; write_rd = 1'b1; retire = 1'b1; end
          OP_AUIPC:  begin alu_insel1 = 2'd1; alu_insel2 = 2'd1; write_rd = 1'b1; retire = 1'b1; end
          OP_JAL,
          OP_JALR:   begin alu_insel1 = 2'd1; alu_insel2 = 2'd2; write_rd = 1'b1; retire = 1'b1; end
          OP_BRANCH,
          OP_MISCMEM: retire = 1'b1;
          OP_OPIMM:  begin alu_insel2 = 2'd1; write_rd = 1'b1; retire = 1'b1; end
          OP_OP: begin
            if (f7_md) begin
              if (MULDIV_EN) state_nxt = S_MD_START;
              else           illegal   = 1'b1;
            end else begin
              write_rd = 1'b1;
              retire   = 1'b1;
            end
          end
          OP_LOAD: begin
            addr_sel   = 1'b1;
            alu_insel2 = 2'd1;
            mem_read   = 1'b1;
            state_nxt  = mem_complete ? S_LOAD_WB : S_LOAD_WAIT;
          end
          OP_STORE: begin
            addr_sel   = 1'b1;
            alu_insel2 = 2'd1;
            mem_write  = 1'b1;
            state_nxt  = mem_complete ? S_STORE_DONE : S_STORE_WAIT;
          end
          OP_SYSTEM: begin
            if (f3 != 3'd0) begin
              rd_sel    = 2'd2;
              write_rd  = 1'b1;
              write_csr = 1'b1;
              retire    = 1'b1;
            end else if (interrupt_pending) begin
              retire = 1'b1;
            end else begin
              state_nxt = S_WFI;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      S_LOAD_WAIT: begin
        addr_sel   = 1'b1;
        alu_insel2 = 2'd1;
        mem_read   = 1'b1;
        if (mem_complete) state_nxt = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        rd_sel   = 2'd1;
        write_rd = 1'b1;
        retire   = 1'b1;
      end
      S_STORE_WAIT: begin
        addr_sel   = 1'b1;
        alu_insel2 = 2'd1;
        mem_write  = 1'b1;
        if (mem_complete) state_nxt = S_STORE_DONE;
      end
      S_STORE_DONE: retire = 1'b1;
      S_MD_START: begin
        md_start  = 1'b1;
        state_nxt = S_MD_WAIT;
      end
      S_MD_WAIT: begin
        if (md_done) begin
          rd_sel   = 2'd3;
          write_rd = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WFI:    if (interrupt_pending) retire = 1'b1;
      S_HALTED: begin
        halted = 1'b1;
        if (resume_req) state_nxt = S_FETCH;
      end
      default:  state_nxt = S_FETCH;
    endcase

    // Retire overlaps the next instruction fetch unless a debug halt is pending
    if (retire) begin
      write_pc_ne = 1'b1;
      if (halt_req) begin
        state_nxt = S_HALTED;
      end else begin
        mem_read  = 1'b1;
        addr_sel  = 1'b0;
        state_nxt = mem_complete ? S_DISPATCH : S_FETCH;
      end
    end

    bus_error = TO_EN && (mem_read || mem_write) && !mem_complete && (cnt == CNT_LAST);
    trap      = (exception || bus_error) && (state != S_HALTED);

    if (trap) begin
      write_pc_ne = 1'b0;
      write_rd    = 1'b0;
      write_csr   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      md_start    = 1'b0;
      addr_sel    = 1'b0;
      rd_sel      = 2'd0;
      alu_insel1  = 2'd0;
      alu_insel2  = 2'd0;
      write_pc_ex = 1'b1;
      state_nxt   = S_FETCH;
    end

    write_pc = write_pc_ne | write_pc_ex;
    write_ir = mem_read & ~addr_sel & mem_complete;

    if (!rst_n) begin
      {write_ir, write_pc, write_pc_ne, write_pc_ex, write_rd, write_csr} = '0;
      {mem_read, mem_write, md_start, addr_sel, bus_error, illegal, halted} = '0;
      rd_sel     = 2'd0;
      alu_insel1 = 2'd0;
      alu_insel2 = 2'd0;
      state_nxt  = S_FETCH;
    end
  end

  // State register and memory-wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (!TO_EN || trap || mem_complete || !(mem_read || mem_write)) cnt <= '0;
      else                                                            cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Directed scoreboard bench for control_seq: per-cycle expected output vectors are queued
// as stimulus is driven and compared on the falling edge.
module tb_control_seq;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [4:0] OP_BAD    = 5'b11111;

  typedef struct packed {
    logic       wir, wpc, wpcne, wpcex, wrd, wcsr, mrd, mwr, mds, asel;
    logic [1:0] rsel, in1, in2;
    logic       berr, ill, hlt;
  } outv_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode;
  logic [2:0] f3;
  logic       f7_md, mem_complete, exception, interrupt_pending, halt_req, resume_req, md_done;

  logic       write_ir, write_pc, write_pc_ne, write_pc_ex, write_rd, write_csr;
  logic       mem_read, mem_write, md_start, addr_sel, bus_error, illegal, halted;
  logic [1:0] rd_sel, alu_insel1, alu_insel2;

  logic       write_ir_b, write_pc_b, write_pc_ne_b, write_pc_ex_b, write_rd_b, write_csr_b;
  logic       mem_read_b, mem_write_b, md_start_b, addr_sel_b, bus_error_b, illegal_b, halted_b;
  logic [1:0] rd_sel_b, alu_insel1_b, alu_insel2_b;

  outv_t act0, act1, e, msk;
  int    n_vec = 0;
  int    n_bad = 0;

  string tq[$];
  outv_t eq[$];
  outv_t mq[$];
  bit    dq[$];

  string m_tag;
  outv_t m_e, m_m, m_a;
  bit    m_w;

  always #5 clk = ~clk;

  control_seq #(.MEM_TIMEOUT(4), .MULDIV_EN(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .f3(f3), .f7_md(f7_md),
    .mem_complete(mem_complete), .exception(exception), .interrupt_pending(interrupt_pending),
    .halt_req(halt_req), .resume_req(resume_req), .md_done(md_done),
    .write_ir(write_ir), .write_pc(write_pc), .write_pc_ne(write_pc_ne), .write_pc_ex(write_pc_ex),
    .write_rd(write_rd), .write_csr(write_csr), .mem_read(mem_read), .mem_write(mem_write),
    .md_start(md_start), .addr_sel(addr_sel), .rd_sel(rd_sel), .alu_insel1(alu_insel1),
    .alu_insel2(alu_insel2), .bus_error(bus_error), .illegal(illegal), .halted(halted)
  );

  control_seq #(.MEM_TIMEOUT(16), .MULDIV_EN(1'b0), .CNT_W(8)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .f3(f3), .f7_md(f7_md),
    .mem_complete(mem_complete), .exception(exception), .interrupt_pending(interrupt_pending),
    .halt_req(halt_req), .resume_req(resume_req), .md_done(md_done),
    .write_ir(write_ir_b), .write_pc(write_pc_b), .write_pc_ne(write_pc_ne_b), .write_pc_ex(write_pc_ex_b),
    .write_rd(write_rd_b), .write_csr(write_csr_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .md_start(md_start_b), .addr_sel(addr_sel_b), .rd_sel(rd_sel_b), .alu_insel1(alu_insel1_b),
    .alu_insel2(alu_insel2_b), .bus_error(bus_error_b), .illegal(illegal_b), .halted(halted_b)
  );

  assign act0 = {write_ir, write_pc, write_pc_ne, write_pc_ex, write_rd, write_csr, mem_read,
                 mem_write, md_start, addr_sel, rd_sel, alu_insel1, alu_insel2, bus_error,
                 illegal, halted};
  assign act1 = {write_ir_b, write_pc_b, write_pc_ne_b, write_pc_ex_b, write_rd_b, write_csr_b,
                 mem_read_b, mem_write_b, md_start_b, addr_sel_b, rd_sel_b, alu_insel1_b,
                 alu_insel2_b, bus_error_b, illegal_b, halted_b};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tq.size() > 0) begin
      m_tag = tq.pop_front();
      m_e   = eq.pop_front();
      m_m   = mq.pop_front();
      m_w   = dq.pop_front();
      m_a   = m_w ? act1 : act0;
      chk(m_tag, 32'(m_a & m_m), 32'(m_e & m_m));
    end
  end

  // Queue the expectation for the cycle whose inputs are currently driven, then advance.
  task automatic step(input string tag, input bit which);
    e.wpc = e.wpcne | e.wpcex;
    e.wir = e.mrd & ~e.asel & mem_complete;
    tq.push_back(tag);
    eq.push_back(e);
    mq.push_back(msk);
    dq.push_back(which);
    @(posedge clk);
    #1;
    e   = '0;
    msk = '1;
  endtask

  task automatic idle_in();
    opcode = 5'd0; f3 = 3'd0; f7_md = 1'b0; mem_complete = 1'b0; exception = 1'b0;
    interrupt_pending = 1'b0; halt_req = 1'b0; resume_req = 1'b0; md_done = 1'b0;
  endtask

  task automatic mask_sel();
    msk.asel = 1'b0; msk.rsel = 2'd0; msk.in1 = 2'd0; msk.in2 = 2'd0;
  endtask

  initial begin
    e = '0; msk = '1;
    idle_in();
    rst_n = 1'b0;
    opcode = OP_LOAD; mem_complete = 1'b1; halt_req = 1'b1; exception = 1'b1;
    @(posedge clk); #1;
    step("rst0", 0);
    step("rst1", 0);

    // Fetch then OPIMM retire
    idle_in();
    rst_n = 1'b1;
    e.mrd = 1; step("fetch_wait", 0);
    mem_complete = 1; e.mrd = 1; step("fetch_done", 0);
    opcode = OP_OPIMM; mem_complete = 0;
    e.wrd = 1; e.in2 = 2'd1; e.wpcne = 1; e.mrd = 1; step("opimm", 0);
    mem_complete = 1; e.mrd = 1; step("fetch2", 0);

    // LOAD with 3-cycle delayed completion
    opcode = OP_LOAD; mem_complete = 0;
    for (int i = 0; i < 3; i++) begin
      e.mrd = 1; e.asel = 1; e.in2 = 2'd1; step("ld_wait", 0);
    end
    mem_complete = 1; e.mrd = 1; e.asel = 1; e.in2 = 2'd1; step("ld_cmpl", 0);
    e.wrd = 1; e.rsel = 2'd1; e.wpcne = 1; e.mrd = 1; step("ld_wb", 0);

    // STORE timeout
    opcode = OP_STORE; mem_complete = 0;
    for (int i = 0; i < 3; i++) begin
      e.mwr = 1; e.asel = 1; e.in2 = 2'd1; step("st_wait", 0);
    end
    e.berr = 1; e.wpcex = 1; mask_sel(); step("st_timeout", 0);
    mem_complete = 1; e.mrd = 1; step("fetch3", 0);

    // mul/div handshake
    opcode = OP_OP; f7_md = 1; mem_complete = 0;
    step("md_disp", 0);
    e.mds = 1; step("md_start", 0);
    for (int i = 0; i < 4; i++) step("md_wait", 0);
    md_done = 1; e.wrd = 1; e.rsel = 2'd3; e.wpcne = 1; e.mrd = 1; step("md_done", 0);
    md_done = 0; mem_complete = 1; e.mrd = 1; step("fetch4", 0);
    mem_complete = 0; step("md_disp2", 0);
    e.mds = 1; step("md_start2", 0);
    md_done = 1; exception = 1; e.wpcex = 1; mask_sel(); step("md_exc", 0);
    exception = 0; e.mrd = 1; step("md_stale", 0);
    md_done = 0; mem_complete = 1; e.mrd = 1; step("fetch5", 0);

    // Debug halt during retire
    f7_md = 0; opcode = OP_OPIMM; halt_req = 1;
    e.wrd = 1; e.in2 = 2'd1; e.wpcne = 1; step("halt_retire", 0);
    halt_req = 0; exception = 1; interrupt_pending = 1; mem_complete = 0;
    e.hlt = 1; step("hlt_exc0", 0);
    e.hlt = 1; step("hlt_exc1", 0);
    exception = 0; interrupt_pending = 0; resume_req = 1;
    e.hlt = 1; step("hlt_resume", 0);
    resume_req = 0; e.mrd = 1; step("resume_fetch", 0);
    mem_complete = 1; e.mrd = 1; step("fetch6", 0);

    // WFI and SYSTEM/other decodes
    opcode = OP_SYSTEM; f3 = 3'd0; mem_complete = 0;
    step("wfi_disp", 0);
    for (int i = 0; i < 10; i++) step("wfi_idle", 0);
    interrupt_pending = 1; mem_complete = 1; e.wpcne = 1; e.mrd = 1; step("wfi_irq", 0);
    interrupt_pending = 0; f3 = 3'd1;
    e.wrd = 1; e.rsel = 2'd2; e.wcsr = 1; e.wpcne = 1; e.mrd = 1; step("csr", 0);
    f3 = 3'd0; opcode = OP_LUI;
    e.wrd = 1; e.in1 = 2'd2; e.in2 = 2'd1; e.wpcne = 1; e.mrd = 1; step("lui", 0);
    opcode = OP_JAL;
    e.wrd = 1; e.in1 = 2'd1; e.in2 = 2'd2; e.wpcne = 1; e.mrd = 1; step("jal", 0);
    opcode = OP_BRANCH; e.wpcne = 1; e.mrd = 1; step("branch", 0);
    opcode = OP_BAD; mem_complete = 0;
    e.ill = 1; step("ill0", 0);
    e.ill = 1; step("ill1", 0);
    exception = 1; e.wpcex = 1; msk.ill = 0; mask_sel(); step("ill_exc", 0);
    exception = 0; mem_complete = 1; e.mrd = 1; step("fetch7", 0);

    // Reset in the middle of a load wait
    opcode = OP_LOAD; mem_complete = 0;
    e.mrd = 1; e.asel = 1; e.in2 = 2'd1; step("ld2_disp", 0);
    e.mrd = 1; e.asel = 1; e.in2 = 2'd1; step("ld2_wait", 0);
    rst_n = 0; step("rst_mid", 0);
    rst_n = 1; halt_req = 1; step("halt_first", 0);
    halt_req = 0; resume_req = 1; e.hlt = 1; step("hlt2", 0);
    resume_req = 0; e.mrd = 1; step("fetch_after", 0);

    // mul/div disabled: OP with f7_md is illegal until exception
    idle_in();
    rst_n = 0; step("rst_b", 1);
    rst_n = 1; mem_complete = 1; e.mrd = 1; step("b_fetch", 1);
    opcode = OP_OP; f7_md = 1; mem_complete = 0;
    for (int i = 0; i < 3; i++) begin
      e.ill = 1; step("b_illegal", 1);
    end
    exception = 1; e.wpcex = 1; msk.ill = 0; mask_sel(); step("b_exc", 1);
    exception = 0; f7_md = 0; e.mrd = 1; step("b_fetch2", 1);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
